// File: rtl/iob_fifo_pkg.sv
// Shared constants and helpers for the iob FIFO family.
// Depth/level widths are functions of ADDR_W so each instance derives its own.
package iob_fifo_pkg;

    localparam int   AFULL_LVL_MIN  = 1;
    localparam int   AEMPTY_LVL_MIN = 0;
    localparam logic R_DATA_RST_BIT = 1'b0;

    function automatic int fifo_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

    function automatic int fifo_level_w(input int addr_w);
        return addr_w + 1;
    endfunction

    function automatic bit afull_lvl_ok(input int lvl, input int addr_w);
        return (lvl >= AFULL_LVL_MIN) && (lvl <= fifo_depth(addr_w));
    endfunction

    function automatic bit aempty_lvl_ok(input int lvl, input int addr_w);
        return (lvl >= AEMPTY_LVL_MIN) && (lvl <= fifo_depth(addr_w) - 1);
    endfunction

endpackage

// File: rtl/iob_ram_2p.sv
// Single-clock two-port RAM: one write port, one registered read port with enable.
// Only the read register is reset; the array itself keeps its contents.
module iob_ram_2p
    import iob_fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_en,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              r_en,
    input  logic [ADDR_W-1:0] r_addr,
    output logic [DATA_W-1:0] r_data
);

    logic [DATA_W-1:0] mem [fifo_depth(ADDR_W)];
    logic [DATA_W-1:0] r_data_q, r_data_d;

    always_ff @(posedge clk) begin
        if (w_en) mem[w_addr] <= w_data;
    end

    always_comb begin
        r_data_d = r_data_q;
        if (r_en) r_data_d = mem[r_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_data_q <= {DATA_W{R_DATA_RST_BIT}};
        else     r_data_q <= r_data_d;
    end

    assign r_data = r_data_q;

endmodule

// File: rtl/iob_sync_fifo.sv
// Synchronous FIFO over iob_ram_2p with level, thresholds and error pulses.
// Define IOB_SYNC_FIFO_FWFT_EN for first-word-fall-through output.
module iob_sync_fifo
    import iob_fifo_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 4,
    parameter int AFULL_LVL  = 14,
    parameter int AEMPTY_LVL = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_en,
    input  logic [DATA_W-1:0] w_data,
    output logic              w_full,
    input  logic              r_en,
    output logic [DATA_W-1:0] r_data,
    output logic              r_empty,
    output logic [ADDR_W:0]   level,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow
);

    localparam int LEVEL_W = fifo_level_w(ADDR_W);
    localparam logic [LEVEL_W-1:0] FULL_L   = LEVEL_W'(fifo_depth(ADDR_W));
    localparam logic [LEVEL_W-1:0] AFULL_L  = LEVEL_W'(AFULL_LVL);
    localparam logic [LEVEL_W-1:0] AEMPTY_L = LEVEL_W'(AEMPTY_LVL);
    localparam logic [LEVEL_W-1:0] LVL_ONE  = LEVEL_W'(1);
    localparam logic [ADDR_W-1:0]  PTR_ONE  = ADDR_W'(1);

    if (!afull_lvl_ok(AFULL_LVL, ADDR_W)) begin : g_bad_afull
        $error("iob_sync_fifo: AFULL_LVL out of range");
    end
    if (!aempty_lvl_ok(AEMPTY_LVL, ADDR_W)) begin : g_bad_aempty
        $error("iob_sync_fifo: AEMPTY_LVL out of range");
    end

    logic [ADDR_W-1:0]  w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic w_full_q, w_full_d, r_empty_q, r_empty_d;
    logic afull_q, afull_d, aempty_q, aempty_d;
    logic ovf_q, ovf_d, unf_q, unf_d;
    logic w_acc, r_acc, ram_ren;
    logic [DATA_W-1:0] ram_rdata;

    assign w_acc = w_en && !w_full_q;
    assign r_acc = r_en && !r_empty_q;

    iob_ram_2p #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
        .clk    (clk),
        .rst    (rst),
        .w_en   (w_acc),
        .w_addr (w_ptr_q),
        .w_data (w_data),
        .r_en   (ram_ren),
        .r_addr (r_ptr_q),
        .r_data (ram_rdata)
    );

    always_comb begin
        w_ptr_d = w_acc   ? w_ptr_q + PTR_ONE : w_ptr_q;
        r_ptr_d = ram_ren ? r_ptr_q + PTR_ONE : r_ptr_q;
        level_d = level_q;
        if (w_acc && !r_acc)      level_d = level_q + LVL_ONE;
        else if (!w_acc && r_acc) level_d = level_q - LVL_ONE;
        w_full_d = (level_d == FULL_L);
        afull_d  = (level_d >= AFULL_L);
        aempty_d = (level_d <= AEMPTY_L);
        ovf_d    = w_en && w_full_q;
        unf_d    = r_en && r_empty_q;
    end

`ifdef IOB_SYNC_FIFO_FWFT_EN
    // Two-slot prefetch: RAM read register, then the visible output register.
    logic [LEVEL_W-1:0] ram_cnt_q, ram_cnt_d;
    logic ram_vld_q, ram_vld_d, out_vld_q, out_vld_d, adv;
    logic [DATA_W-1:0] out_q, out_d;

    always_comb begin
        adv       = ram_vld_q && (!out_vld_q || r_acc);
        ram_ren   = (ram_cnt_q != '0) && (!ram_vld_q || adv);
        ram_cnt_d = ram_cnt_q;
        if (w_acc && !ram_ren)      ram_cnt_d = ram_cnt_q + LVL_ONE;
        else if (!w_acc && ram_ren) ram_cnt_d = ram_cnt_q - LVL_ONE;
        ram_vld_d = ram_ren || (ram_vld_q && !adv);
        out_vld_d = adv || (out_vld_q && !r_acc);
        out_d     = adv ? ram_rdata : out_q;
        r_empty_d = !out_vld_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_cnt_q <= '0;
            ram_vld_q <= 1'b0;
            out_vld_q <= 1'b0;
            out_q     <= {DATA_W{R_DATA_RST_BIT}};
        end else begin
            ram_cnt_q <= ram_cnt_d;
            ram_vld_q <= ram_vld_d;
            out_vld_q <= out_vld_d;
            out_q     <= out_d;
        end
    end

    assign r_data = out_q;
`else
    assign ram_ren   = r_acc;
    assign r_empty_d = (level_d == '0);
    assign r_data    = ram_rdata;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_ptr_q   <= '0;
            r_ptr_q   <= '0;
            level_q   <= '0;
            w_full_q  <= 1'b0;
            r_empty_q <= 1'b1;
            afull_q   <= 1'b0;
            aempty_q  <= 1'b1;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            w_ptr_q   <= w_ptr_d;
            r_ptr_q   <= r_ptr_d;
            level_q   <= level_d;
            w_full_q  <= w_full_d;
            r_empty_q <= r_empty_d;
            afull_q   <= afull_d;
            aempty_q  <= aempty_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    assign w_full       = w_full_q;
    assign r_empty      = r_empty_q;
    assign level        = level_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_iob_sync_fifo.sv
// Randomized scoreboard bench for iob_sync_fifo against a queue model.
// With IOB_SYNC_FIFO_FWFT_EN defined, a directed fall-through sequence runs instead.
module tb_iob_sync_fifo;

    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       w_en = 1'b0;
    logic       r_en = 1'b0;
    logic [7:0] w_data = 8'h00;
    logic       w_full, r_empty, almost_full, almost_empty, overflow, underflow;
    logic [7:0] r_data;
    logic [4:0] level;

    int checks = 0;
    int errors = 0;
    int mq[$];
    int sbq[$];
    int exp_rdata = 0;
    bit mon_en = 1'b0;
    logic mon_fire;

    iob_sync_fifo #(.DATA_W(8), .ADDR_W(4), .AFULL_LVL(AF), .AEMPTY_LVL(AE)) dut (
        .clk          (clk),
        .rst          (rst),
        .w_en         (w_en),
        .w_data       (w_data),
        .w_full       (w_full),
        .r_en         (r_en),
        .r_data       (r_data),
        .r_empty      (r_empty),
        .level        (level),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_flags(input int ovf, input int unf);
        int l;
        l = mq.size();
        chk("level",        32'(level),        32'(l));
        chk("w_full",       32'(w_full),       32'(l == DEPTH));
        chk("r_empty",      32'(r_empty),      32'(l == 0));
        chk("almost_full",  32'(almost_full),  32'(l >= AF));
        chk("almost_empty", 32'(almost_empty), 32'(l <= AE));
        chk("overflow",     32'(overflow),     32'(ovf));
        chk("underflow",    32'(underflow),    32'(unf));
    endtask

    // One clock of stimulus; the model decides acceptance from its own occupancy.
    task automatic cycle(input logic we, input logic re, input logic [7:0] wd);
        bit full, empty;
        int ovf, unf;
        @(negedge clk);
        w_en = we; r_en = re; w_data = wd;
        @(posedge clk);
        full  = (mq.size() == DEPTH);
        empty = (mq.size() == 0);
        ovf   = (we && full) ? 1 : 0;
        unf   = (re && empty) ? 1 : 0;
        if (re && !empty) sbq.push_back(mq.pop_front());
        if (we && !full)  mq.push_back(int'(wd));
        #1 check_flags(ovf, unf);
    endtask

    task automatic drive(input logic we, input logic re, input logic [7:0] wd);
        @(negedge clk);
        w_en = we; r_en = re; w_data = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        w_en = 1'b0; r_en = 1'b0; rst = 1'b1;
        #1;
        mq.delete(); sbq.delete(); exp_rdata = 0;
        check_flags(0, 0);
        chk("r_data_rst", 32'(r_data), 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

`ifndef IOB_SYNC_FIFO_FWFT_EN
    // r_data must follow the scoreboard one cycle after each accepted read and hold otherwise.
    always @(posedge clk) begin
        mon_fire = r_en && !r_empty && !rst;
        #1;
        if (rst) begin
            exp_rdata = 0;
        end else if (mon_en) begin
            if (mon_fire) begin
                if (sbq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL r_data_pop no expected word queued t=%0t", $time);
                end else begin
                    exp_rdata = sbq.pop_front();
                end
            end
            chk("r_data", 32'(r_data), 32'(exp_rdata));
        end
    end
`endif

    initial begin
        do_reset();
`ifdef IOB_SYNC_FIFO_FWFT_EN
        drive(1'b1, 1'b0, 8'h11);
        chk("fwft_empty_n1", 32'(r_empty), 32'h1);
        chk("fwft_level_n1", 32'(level),   32'h1);
        drive(1'b0, 1'b0, 8'h00);
        chk("fwft_empty_n2", 32'(r_empty), 32'h1);
        drive(1'b0, 1'b0, 8'h00);
        chk("fwft_empty_n3", 32'(r_empty), 32'h0);
        chk("fwft_data_n3",  32'(r_data),  32'h11);
        drive(1'b0, 1'b1, 8'h00);
        chk("fwft_pop_empty", 32'(r_empty), 32'h1);
        chk("fwft_pop_level", 32'(level),   32'h0);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 8'(8'h20 + i));
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            chk("fwft_head", 32'(r_data),  32'(8'h20 + i));
            chk("fwft_vld",  32'(r_empty), 32'h0);
            drive(1'b0, 1'b1, 8'h00);
        end
        chk("fwft_drained", 32'(r_empty), 32'h1);
        chk("fwft_level0",  32'(level),   32'h0);
`else
        mon_en = 1'b1;
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 8'(32 + i));
        cycle(1'b1, 1'b0, 8'hFF);
        cycle(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
        chk("r_data_hold", 32'(r_data), 32'd47);

        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'($urandom));
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 8'($urandom));
        while (mq.size() > 0) cycle(1'b0, 1'b1, 8'h00);

        cycle(1'b1, 1'b1, 8'hA5);
        cycle(1'b0, 1'b1, 8'h00);
        chk("a5_read", 32'(r_data), 32'hA5);

        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 8'($urandom));
        cycle(1'b1, 1'b1, 8'h5A);
        cycle(1'b0, 1'b0, 8'h00);

        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8'(8'h60 + i));
        do_reset();
        cycle(1'b1, 1'b0, 8'h3C);
        cycle(1'b0, 1'b1, 8'h00);
        chk("after_rst_3c", 32'(r_data), 32'h3C);

        // Phases alternate write-heavy and read-heavy to sweep full and empty repeatedly.
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < 50; i++) begin
                int wp;
                wp = p[0] ? 30 : 75;
                cycle(($urandom_range(0, 99) < wp) ? 1'b1 : 1'b0,
                      ($urandom_range(0, 99) < (100 - wp)) ? 1'b1 : 1'b0,
                      8'($urandom));
            end
        end
        while (mq.size() > 0) cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
        chk("sb_drained", 32'(sbq.size()), 32'h0);
`endif
        @(negedge clk);
        w_en = 1'b0; r_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iob_sync_fifo.md
Name: iob_sync_fifo

Overview:
Single-clock, parametrised synchronous FIFO built on a registered-read two-port RAM. It generalises the plain two-port RAM into a buffered queue with full/empty flags, occupancy level, programmable almost-full/almost-empty thresholds and error pulses. It sits between producer and consumer blocks in the same clock domain, for example UART or DMA buffering.

Parameters:
DATA_W, 8, word width in bits.
ADDR_W, 4, address width; depth = 2**ADDR_W words.
AFULL_LVL, 14, almost_full asserts when level >= AFULL_LVL (range 1..2**ADDR_W).
AEMPTY_LVL, 2, almost_empty asserts when level <= AEMPTY_LVL (range 0..2**ADDR_W-1).

Ports:
clk  in  1  system clock, all logic on rising edge.
rst  in  1  asynchronous active-high reset.
w_en  in  1  write request.
w_data  in  DATA_W  write data.
w_full  out  1  FIFO full; writes ignored.
r_en  in  1  read request.
r_data  out  DATA_W  read data.
r_empty  out  1  FIFO empty; reads ignored.
level  out  ADDR_W+1  number of stored words, 0..2**ADDR_W.
almost_full  out  1  level >= AFULL_LVL.
almost_empty  out  1  level <= AEMPTY_LVL.
overflow  out  1  one-cycle pulse: w_en while w_full.
underflow  out  1  one-cycle pulse: r_en while r_empty.

Behaviour:
- Reset (async assert, sync release): w_ptr=0, r_ptr=0, level=0, r_empty=1, w_full=0, r_data=0, almost_empty=1, almost_full=0, overflow=0, underflow=0. RAM contents are not cleared.
- Write accepted iff w_en && !w_full: RAM[w_ptr] <= w_data, w_ptr++.
- Read accepted iff r_en && !r_empty: r_data <= RAM[r_ptr] on that edge (valid the cycle after the request), r_ptr++. r_data holds its last value when no read is accepted.
- Pointers are ADDR_W bits and wrap 2**ADDR_W-1 -> 0 with no special handling.
- level register: +1 on write only, -1 on read only, unchanged on both or neither.
- All flags are registered from next-level: w_full = (level==2**ADDR_W); r_empty = (level==0).
- Simultaneous read and write:
  - when full: read accepted, write rejected (overflow pulses), level becomes 2**ADDR_W-1.
  - when empty: write accepted, read rejected (underflow pulses), level becomes 1.
  - otherwise: both accepted, level unchanged.
- Write-to-read visibility: a word written at edge N is readable by a request at edge N+1. No same-cycle RAM bypass.
- overflow/underflow are registered, high for exactly the cycle after the offending request.
- Reset mid-operation clears all state immediately; no data survives.

Optional Feature:
Macro IOB_SYNC_FIFO_FWFT_EN.
- Defined (first-word-fall-through): an output register prefetches the head word, and r_data shows it whenever !r_empty. r_en acts as a pop/acknowledge and the next word appears the following cycle.
  - First write into an empty FIFO at edge N gives r_empty=0 with valid r_data after edge N+2.
  - level counts the prefetched word.
  - w_full, level and thresholds are otherwise unchanged.
- Undefined: standard mode as above, with 1-cycle read latency.

Decomposition:
- Shared package iob_fifo_pkg holds:
  - localparam helpers DEPTH = 2**ADDR_W and LEVEL_W = ADDR_W+1.
  - flag-threshold range-check constants.
  - the reset value constant for r_data.
- One sub-module, iob_ram_2p: single-clock, one write port and one read port, registered read with read enable. The FIFO control (pointers, level, flags, FWFT prefetch) stays in iob_sync_fifo.

Test Plan:
- Reset, then write 16 words 32..47 -> level 0..16, almost_full at level 14, w_full=1 at 16; a 17th w_en -> overflow pulses 1 cycle, level stays 16.
- From full, read 16 words -> r_data sequence 32..47, each 1 cycle after r_en; r_empty=1 at level 0; an extra r_en -> underflow pulse, r_data holds 47.
- At level 5, assert w_en and r_en together for 20 cycles -> level stays 5; read data order correct across pointer wrap 15->0.
- Empty, w_en and r_en together with w_data=0xA5 -> level=1, underflow=1, r_data unchanged; next-cycle read returns 0xA5. Full with both asserted -> level=15, overflow=1.
- Write 8 words, assert rst mid-stream for 1 cycle -> all outputs return to reset values immediately; a subsequent write/read of 0x3C returns 0x3C.
- With IOB_SYNC_FIFO_FWFT_EN: write 0x11 into an empty FIFO -> r_data=0x11 and r_empty=0 two cycles later with no r_en; pop -> r_empty=1 next cycle.
